// File: rtl/logic_unit_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Two requesters share one WIDTH-bit bitwise logic unit. Each requester
// presents an op over a valid/ready handshake. Grants are round-robin, and
// only one op is in flight at a time. Each result comes back on a single
// response channel, tagged with the id of the requester and an illegal-op flag.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   req_valid  [1:0] bit i: requester i presents an op
//   req_ready  [1:0] bit i: op from requester i accepted this cycle
//   req0_op/a/b, req1_op/a/b   opcode (3b) and operands (WIDTH) per requester
//   rsp_valid  response available
//   rsp_ready  consumer takes response
//   rsp_id     requester that issued the op
//   rsp_data   result (WIDTH)
//   rsp_err    1 = illegal opcode
//   ops_done   completed responses, wraps modulo 2^CNT_W
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; req_ready granted combinationally
// EXEC  | compute on the latched op/operands, register the response
// RESP  | response presented; held until rsp_ready
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    state_t           state;
    state_t           state_nxt;

    logic             last_grant;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic             rsp_take;

    logic [WIDTH-1:0] alu_data;
    logic             alu_err;

    // ---------------------------------------------------------------------
    // Round-robin grant: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    // ---------------------------------------------------------------------
    always_comb begin
        grant_any = |req_valid;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    assign accept   = (state == ST_IDLE) && grant_any;
    assign rsp_take = (state == ST_RESP) && rsp_ready;

    // Gated by rst so the handshake is quiet while reset is held, even
    // though the FSM already sits in IDLE.
    always_comb begin
        req_ready = 2'b00;
        if (accept && !rst) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_any) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Operand capture. The logic unit only ever sees these registers, so
    // requesters changing their ports after the grant has no effect.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 3'd0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            id_q <= grant_id;
            if (grant_id) begin
                op_q <= req1_op;
                a_q  <= req1_a;
                b_q  <= req1_b;
            end else begin
                op_q <= req0_op;
                a_q  <= req0_a;
                b_q  <= req0_b;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Bitwise logic unit
    // ---------------------------------------------------------------------
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        case (op_q)
            OP_NOT:  alu_data = ~a_q;
            OP_AND:  alu_data = a_q & b_q;
            OP_OR:   alu_data = a_q | b_q;
            OP_NAND: alu_data = ~(a_q & b_q);
            OP_NOR:  alu_data = ~(a_q | b_q);
            OP_XOR:  alu_data = a_q ^ b_q;
            OP_XNOR: alu_data = ~(a_q ^ b_q);
            default: begin
                alu_data = '0;
                alu_err  = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Response channel. Only EXEC writes the payload, so it stays stable for
    // as long as RESP waits on the consumer.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= alu_data;
            rsp_err   <= alu_err;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

    // last_grant starts at 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            ops_done   <= '0;
        end else if (rsp_take) begin
            last_grant <= rsp_id;
            ops_done   <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req0_op;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic [2:0]  req1_op;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [15:0] ops_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic_unit_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op from a single requester, check the grant, drop valid.
    // Returns at the negedge of the EXEC cycle.
    task automatic issue(input bit id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_op = op; req0_a = a; req0_b = b;
        end
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        chk("grant", {30'd0, req_ready}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    // Expect the response in the cycle after EXEC, then consume it.
    task automatic expect_rsp(input string tag, input bit id,
                              input logic [7:0] data, input bit err);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
        chk({tag, "_data"},  {24'd0, rsp_data},  {24'd0, data});
        chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_clear"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] exp_ops [7];

    initial begin
        exp_ops = '{8'h5A, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55};
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
        req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;

        // Reset values, with both requesters asserting valid
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_ops_done",  {16'd0, ops_done},  32'd0);
        chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
        chk("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        req_valid = 2'b00;
        rst = 1'b0;

        // 1. single requester, AND
        issue(1'b0, 3'd1, 8'hF0, 8'h3C);
        expect_rsp("t1", 1'b0, 8'h30, 1'b0);
        chk("t1_ops_done", {16'd0, ops_done}, 32'd1);

        // 2. every legal op
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, 3'(i), 8'hA5, 8'h0F);
            expect_rsp($sformatf("t2_op%0d", i), 1'b0, exp_ops[i], 1'b0);
        end
        chk("t2_ops_done", {16'd0, ops_done}, 32'd8);

        // 5. illegal op from req1, then a legal one
        issue(1'b1, 3'd7, 8'hFF, 8'hFF);
        expect_rsp("t5_ill", 1'b1, 8'h00, 1'b1);
        issue(1'b1, 3'd1, 8'hFF, 8'h3C);
        expect_rsp("t5_ok", 1'b1, 8'h3C, 1'b0);

        // 3. both valid continuously from a fresh reset
        do_reset();
        begin
            int ng;
            int nr;
            ng = 0;
            nr = 0;
            @(negedge clk);
            req0_op = 3'd1; req0_a = 8'hF0; req0_b = 8'h3C;
            req1_op = 3'd5; req1_a = 8'hFF; req1_b = 8'h0F;
            rsp_ready = 1'b1;
            req_valid = 2'b11;
            for (int c = 0; c < 20 && nr < 4; c++) begin
                #1;
                if (req_ready != 2'b00) begin
                    chk("t3_grant", {30'd0, req_ready}, (ng % 2) ? 32'd2 : 32'd1);
                    ng++;
                end
                if (rsp_valid) begin
                    chk("t3_id",   {31'd0, rsp_id},   32'(nr % 2));
                    chk("t3_data", {24'd0, rsp_data}, (nr % 2) ? 32'hF0 : 32'h30);
                    nr++;
                    if (nr == 4) req_valid = 2'b00;
                end
                if (nr < 4) @(negedge clk);
            end
            chk("t3_rsp_count", 32'(nr), 32'd4);
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("t3_ops_done", {16'd0, ops_done}, 32'd4);
        end

        // 4. backpressure: response held, no grants, resume one cycle later
        issue(1'b0, 3'd2, 8'hA5, 8'h0F);
        req1_op = 3'd6; req1_a = 8'hA5; req1_b = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_data",  {24'd0, rsp_data},  32'hAF);
            chk("t4_hold_id",    {31'd0, rsp_id},    32'd0);
            chk("t4_no_ready",   {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("t4_resume", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        expect_rsp("t4_next", 1'b1, 8'h55, 1'b0);
        chk("t4_ops_done", {16'd0, ops_done}, 32'd6);

        // 6a. reset while in EXEC
        issue(1'b1, 3'd1, 8'hFF, 8'h0F);
        rst = 1'b1;
        #1;
        chk("t6e_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6e_ops_done",  {16'd0, ops_done},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6e_no_stale", {31'd0, rsp_valid}, 32'd0);

        // 6b. reset while in RESP
        issue(1'b0, 3'd2, 8'h0F, 8'hF0);
        expect_rsp("t6_pre", 1'b0, 8'hFF, 1'b0);
        issue(1'b1, 3'd5, 8'hFF, 8'h0F);
        @(negedge clk);
        chk("t6r_in_resp", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6r_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6r_rsp_data",  {24'd0, rsp_data},  32'd0);
        chk("t6r_rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("t6r_ops_done",  {16'd0, ops_done},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First tie after reset goes to req0
        @(negedge clk);
        req0_op = 3'd3; req0_a = 8'hFF; req0_b = 8'h0F;
        req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
        req_valid = 2'b11;
        #1;
        chk("t6_tie", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        expect_rsp("t6_post", 1'b0, 8'hF0, 1'b0);
        chk("t6_ops_done", {16'd0, ops_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
